// File: rtl/had_trace_step_ctrl_if.sv
// ---------------------------------------------------------------------------
// had_trace_step_ctrl_if
//
// Bundles the register-file, retire-stage and debug-status signals that
// surround the HAD trace/step controller, so the controller can be wired up
// with a single port.
//
//   master : the surrounding logic (HAD register file, IU retire stage,
//            other HAD debug sources). It drives the control and status
//            inputs and observes the trace outputs.
//   slave  : the trace/step controller itself.
//
// Signals (direction as seen by the slave):
//   regs_trace_en            in   trace-mode enable level
//   regs_tc_wr               in   one-cycle trace-counter write strobe
//   regs_tc_wdata            in   trace-counter write value
//   iu_had_xx_retire         in   an instruction retires this cycle
//   iu_had_xx_retire_normal  in   the retiring instruction had no exception
//   iu_had_xx_mldst          in   the retire is a multi-load/store beat
//   iu_yy_xx_dbgon           in   the core is in debug mode
//   had_other_dbg_req        in   another HAD source is requesting debug
//   trace_inst_vld           out  a qualified retire was counted this cycle
//   trace_dbg_req            out  registered debug-mode request to the core
//   trace_cnt                out  current trace counter value
//   trace_expire             out  sticky "trace count expired" status
// ---------------------------------------------------------------------------
interface had_trace_step_ctrl_if #(
    parameter int CNT_WIDTH = 8
);

    logic                 regs_trace_en;
    logic                 regs_tc_wr;
    logic [CNT_WIDTH-1:0] regs_tc_wdata;
    logic                 iu_had_xx_retire;
    logic                 iu_had_xx_retire_normal;
    logic                 iu_had_xx_mldst;
    logic                 iu_yy_xx_dbgon;
    logic                 had_other_dbg_req;
    logic                 trace_inst_vld;
    logic                 trace_dbg_req;
    logic [CNT_WIDTH-1:0] trace_cnt;
    logic                 trace_expire;

    modport master (
        output regs_trace_en,
        output regs_tc_wr,
        output regs_tc_wdata,
        output iu_had_xx_retire,
        output iu_had_xx_retire_normal,
        output iu_had_xx_mldst,
        output iu_yy_xx_dbgon,
        output had_other_dbg_req,
        input  trace_inst_vld,
        input  trace_dbg_req,
        input  trace_cnt,
        input  trace_expire
    );

    modport slave (
        input  regs_trace_en,
        input  regs_tc_wr,
        input  regs_tc_wdata,
        input  iu_had_xx_retire,
        input  iu_had_xx_retire_normal,
        input  iu_had_xx_mldst,
        input  iu_yy_xx_dbgon,
        input  had_other_dbg_req,
        output trace_inst_vld,
        output trace_dbg_req,
        output trace_cnt,
        output trace_expire
    );

endinterface

// File: rtl/had_trace_step_ctrl.sv
// ---------------------------------------------------------------------------
// had_trace_step_ctrl
//
// Debug trace/step controller inside the HAD. While trace mode is armed it
// counts qualified retiring instructions down from a debugger-programmed
// value; when the count runs out it raises a debug-mode request to the core
// and holds it until the core reports that it has entered debug mode. After
// the core leaves debug mode, tracing re-arms if trace mode is still enabled.
//
// Ports:
//   forever_cpuclk  in   core clock, all state changes on the rising edge
//   cpurst_b        in   asynchronous active-low reset
//   bus             slave side of had_trace_step_ctrl_if (control inputs,
//                        retire/debug status inputs, trace outputs)
// ---------------------------------------------------------------------------
module had_trace_step_ctrl #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    had_trace_step_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        REQ   = 2'd2,
        DBG   = 2'd3
    } traceState_e;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    traceState_e          state_q;
    logic                 dbgReq_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 expire_q;
    logic                 expire_d;

    logic                 qualRetire;
    logic                 countExpire;

    // A retire only counts while armed, when it completed normally, is not a
    // multi-load/store beat, and no debug entry is underway or pending.
    assign qualRetire = bus.iu_had_xx_retire
                      & bus.iu_had_xx_retire_normal
                      & ~bus.iu_had_xx_mldst
                      & ~bus.iu_yy_xx_dbgon
                      & ~bus.had_other_dbg_req
                      & bus.regs_trace_en
                      & (state_q == ARMED);

    // The Nth qualified retire after loading N expires; a load of 0 behaves
    // like a load of 1. A same-cycle counter write overrides the retire.
    assign countExpire = qualRetire & ~bus.regs_tc_wr & (cnt_q <= CNT_ONE);

    // Counter next value: a write wins, otherwise a qualified retire
    // decrements and the count sticks at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.regs_tc_wr) begin
            cnt_d = bus.regs_tc_wdata;
        end else if (qualRetire && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    // Sticky expiry flag: set together with the move into REQ, cleared by a
    // counter write. Both cannot happen at once since a write blocks expiry.
    always_comb begin
        expire_d = expire_q;
        if (countExpire) begin
            expire_d = 1'b1;
        end else if (bus.regs_tc_wr) begin
            expire_d = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    // Trace sequencing FSM with the registered debug request. Once REQ is
    // entered the request is held regardless of enable or counter writes,
    // and only drops when the core reports debug mode. Debug entry from any
    // other source while armed parks the FSM in DBG without touching the
    // count, so tracing resumes where it left off.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= IDLE;
            dbgReq_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    dbgReq_q <= 1'b0;
                    if (bus.regs_trace_en && !bus.iu_yy_xx_dbgon) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (countExpire) begin
                        state_q  <= REQ;
                        dbgReq_q <= 1'b1;
                    end else if (bus.iu_yy_xx_dbgon) begin
                        state_q <= DBG;
                    end else if (!bus.regs_trace_en) begin
                        state_q <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.iu_yy_xx_dbgon) begin
                        state_q  <= DBG;
                        dbgReq_q <= 1'b0;
                    end
                end
                DBG: begin
                    dbgReq_q <= 1'b0;
                    if (!bus.iu_yy_xx_dbgon) begin
                        state_q <= bus.regs_trace_en ? ARMED : IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    dbgReq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trace_inst_vld = qualRetire;
    assign bus.trace_dbg_req  = dbgReq_q;
    assign bus.trace_cnt      = cnt_q;
    assign bus.trace_expire   = expire_q;

endmodule
